// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered read data and registered full/empty flags.
// Depth need not be a power of two; pointers wrap explicitly at DEPTH-1.
module sync_fifo #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned DEPTH      = 16
) (
  input  logic                  clk,
  input  logic                  rst_,
  input  logic                  wr_en,
  input  logic                  rd_en,
  input  logic [DATA_WIDTH-1:0] din,
  output logic [DATA_WIDTH-1:0] dout,
  output logic                  full,
  output logic                  empty
);

  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CntW = $clog2(DEPTH + 1);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic [PtrW-1:0]       wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]       rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]       count_q, count_d;
  logic [DATA_WIDTH-1:0] dout_q;
  logic                  full_q, empty_q;
  logic                  wr_acc, rd_acc;

  assign wr_acc = wr_en & ~full_q;
  assign rd_acc = rd_en & ~empty_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (wr_acc) begin
      wr_ptr_d = (wr_ptr_q == PtrW'(DEPTH - 1)) ? '0 : wr_ptr_q + PtrW'(1);
    end
    if (rd_acc) begin
      rd_ptr_d = (rd_ptr_q == PtrW'(DEPTH - 1)) ? '0 : rd_ptr_q + PtrW'(1);
    end
    unique case ({wr_acc, rd_acc})
      2'b10:   count_d = count_q + CntW'(1);
      2'b01:   count_d = count_q - CntW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      dout_q   <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      // Flags come from the next-state count so they are valid right after the edge.
      full_q   <= (count_d == CntW'(DEPTH));
      empty_q  <= (count_d == '0);
      if (rd_acc) begin
        dout_q <= mem[rd_ptr_q];
      end
    end
  end

  // Storage is deliberately not reset; a write coinciding with reset is suppressed.
  always_ff @(posedge clk) begin
    if (rst_ && wr_acc) begin
      mem[wr_ptr_q] <= din;
    end
  end

  assign dout  = dout_q;
  assign full  = full_q;
  assign empty = empty_q;

endmodule

// File: tb/tb_sync_fifo.sv
// Scoreboard bench for sync_fifo: the driver queues per-cycle expected outputs,
// a monitor pops and compares them just after each rising edge.
module tb_sync_fifo;

  localparam int unsigned DW    = 8;
  localparam int unsigned DEPTH = 16;

  typedef struct packed {
    logic [DW-1:0] dout;
    logic          full;
    logic          empty;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst_;
  logic          wr_en;
  logic          rd_en;
  logic [DW-1:0] din;
  logic [DW-1:0] dout;
  logic          full;
  logic          empty;

  exp_t          exp_q [$];
  logic [DW-1:0] model_q [$];
  logic [DW-1:0] model_dout;
  int            checks = 0;
  int            errors = 0;
  int            cyc    = 0;

  sync_fifo #(
    .DATA_WIDTH(DW),
    .DEPTH     (DEPTH)
  ) dut (
    .clk  (clk),
    .rst_ (rst_),
    .wr_en(wr_en),
    .rd_en(rd_en),
    .din  (din),
    .dout (dout),
    .full (full),
    .empty(empty)
  );

  always #5 clk = ~clk;

  // Monitor: one expected record per clock edge issued by the driver.
  always @(posedge clk) begin
    exp_t e;
    #1;
    cyc++;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (dout !== e.dout) begin
        errors++;
        $display("FAIL dout cyc=%0d got=%02h exp=%02h", cyc, dout, e.dout);
      end
      checks++;
      if (full !== e.full) begin
        errors++;
        $display("FAIL full cyc=%0d got=%b exp=%b", cyc, full, e.full);
      end
      checks++;
      if (empty !== e.empty) begin
        errors++;
        $display("FAIL empty cyc=%0d got=%b exp=%b", cyc, empty, e.empty);
      end
      checks++;
      if (full && empty) begin
        errors++;
        $display("FAIL full_and_empty cyc=%0d got=11 exp=not both", cyc);
      end
    end
  end

  // Apply one cycle of stimulus (called at a falling edge) and queue the expected result.
  task automatic step(input logic r, input logic w, input logic rd, input logic [DW-1:0] d);
    logic wa, ra;
    rst_  = r;
    wr_en = w;
    rd_en = rd;
    din   = d;
    if (!r) begin
      model_q.delete();
      model_dout = '0;
    end else begin
      wa = w && (model_q.size() < DEPTH);
      ra = rd && (model_q.size() > 0);
      if (ra) model_dout = model_q.pop_front();
      if (wa) model_q.push_back(d);
    end
    exp_q.push_back('{dout: model_dout, full: (model_q.size() == DEPTH),
                      empty: (model_q.size() == 0)});
    @(negedge clk);
  endtask

  initial begin
    rst_       = 1'b0;
    wr_en      = 1'b0;
    rd_en      = 1'b0;
    din        = '0;
    model_dout = '0;
    @(negedge clk);

    // Reset held two cycles with requests asserted.
    step(1'b0, 1'b1, 1'b1, 8'hFF);
    step(1'b0, 1'b1, 1'b1, 8'hFF);

    // Fill then drain.
    for (int i = 0; i < 16; i++) step(1'b1, 1'b1, 1'b0, DW'(i));
    for (int i = 0; i < 16; i++) step(1'b1, 1'b0, 1'b1, 8'h00);

    // Overflow: 17th write dropped.
    for (int i = 0; i < 17; i++) step(1'b1, 1'b1, 1'b0, DW'(i));
    for (int i = 0; i < 16; i++) step(1'b1, 1'b0, 1'b1, 8'h00);

    // Underflow: 17th read leaves dout at 15.
    for (int i = 0; i < 16; i++) step(1'b1, 1'b1, 1'b0, DW'(i));
    for (int i = 0; i < 17; i++) step(1'b1, 1'b0, 1'b1, 8'h00);
    step(1'b1, 1'b0, 1'b0, 8'h00);

    // Simultaneous read+write: empty, one word, then full.
    step(1'b1, 1'b1, 1'b1, 8'hA5);
    step(1'b1, 1'b1, 1'b1, 8'h5A);
    for (int i = 0; i < 15; i++) step(1'b1, 1'b1, 1'b0, DW'(8'h80 + i));
    step(1'b1, 1'b1, 1'b1, 8'hEE);
    for (int i = 0; i < 16; i++) step(1'b1, 1'b0, 1'b1, 8'h00);

    // Reset mid-stream discards contents and clears dout.
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b0, DW'(8'h30 + i));
    step(1'b0, 1'b1, 1'b1, 8'h77);
    step(1'b1, 1'b0, 1'b1, 8'h00);
    step(1'b1, 1'b0, 1'b1, 8'h00);

    // Wrap-around: mostly-write and mostly-read phases with overlap.
    for (int i = 0; i < 40; i++) begin
      step(1'b1, ((i / 10) % 2 == 0) || (i % 3 == 0),
           ((i / 10) % 2 == 1) || (i % 4 == 0), DW'(8'h40 + i));
    end
    for (int i = 0; i < 17; i++) step(1'b1, 1'b0, 1'b1, 8'h00);

    wr_en = 1'b0;
    rd_en = 1'b0;
    @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain got=%0d pending exp=0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
